// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one single-port cache between instruction fetch (port 0)
// and load/store (port 1), with saturating per-port access and miss statistics.
module cache_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p0_ready,
  output logic [31:0]       p0_rdata,
  output logic              p1_ready,
  output logic [31:0]       p1_rdata,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_rd_req,
  output logic              c_wr_req,
  output logic [31:0]       c_wr_data,
  input  logic [31:0]       c_rd_data,
  input  logic              c_miss,
  output logic [CNT_W-1:0]  acc_cnt0,
  output logic [CNT_W-1:0]  acc_cnt1,
  output logic [CNT_W-1:0]  miss_cnt0,
  output logic [CNT_W-1:0]  miss_cnt1
);

  typedef enum logic [1:0] {ARB, ISSUE, RESP} state_t;

  state_t            state, state_next;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic              gnt_id;
  logic              last_gnt;
  logic              saw_miss;
  logic              grant;
  logic              grant_id;
  logic              issuing;

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_id   = 1'b0;
    case (state)
      ARB: begin
        // On contention the port that was not served last wins.
        if (p0_req && p1_req) begin
          grant    = 1'b1;
          grant_id = ~last_gnt;
        end else if (p0_req) begin
          grant    = 1'b1;
          grant_id = 1'b0;
        end else if (p1_req) begin
          grant    = 1'b1;
          grant_id = 1'b1;
        end
        if (grant) state_next = ISSUE;
      end
      ISSUE:   if (!c_miss) state_next = RESP;
      RESP:    state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      gnt_id    <= 1'b0;
      last_gnt  <= 1'b1;
      saw_miss  <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        cur_we    <= grant_id ? p1_we    : p0_we;
        cur_addr  <= grant_id ? p1_addr  : p0_addr;
        cur_wdata <= grant_id ? p1_wdata : p0_wdata;
        gnt_id    <= grant_id;
        saw_miss  <= 1'b0;
      end
      if (state == ISSUE) begin
        if (c_miss) saw_miss <= 1'b1;
        else        last_gnt <= gnt_id;
      end
    end
  end

  assign issuing   = (state == ISSUE);
  assign c_rd_req  = issuing & ~cur_we;
  assign c_wr_req  = issuing & cur_we;
  assign c_addr    = issuing ? cur_addr  : '0;
  assign c_wr_data = issuing ? cur_wdata : '0;

  assign p0_ready = (state == RESP) && !gnt_id;
  assign p1_ready = (state == RESP) && gnt_id;
  assign p0_rdata = c_rd_data;
  assign p1_rdata = c_rd_data;

  // Statistics close out in RESP, so they become visible the cycle after ready.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] miss;
    logic             served;

    assign served = (state == RESP) && (gnt_id == 1'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc  <= '0;
        miss <= '0;
      end else if (served) begin
        if (acc != '1)              acc  <= acc + 1'b1;
        if (saw_miss && miss != '1) miss <= miss + 1'b1;
      end
    end
  end

  assign acc_cnt0  = g_cnt[0].acc;
  assign acc_cnt1  = g_cnt[1].acc;
  assign miss_cnt0 = g_cnt[0].miss;
  assign miss_cnt1 = g_cnt[1].miss;

endmodule
